// File: rtl/mw_result_stage_pkg.sv
// Shared opcode constants and instruction field helpers for the M-to-W result stage.
package mw_result_stage_pkg;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LHU  = 6'h25;
  localparam logic [5:0] OP_LBU  = 6'h24;
  localparam logic [5:0] OP_COP0 = 6'h10;
  localparam logic [4:0] RS_MFC0 = 5'h00;

  function automatic logic [5:0] instr_op(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] instr_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB) ||
           (op == OP_LHU) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/mw_load_tracker.sv
// Load-return tracker: IDLE/WAIT/DRAIN FSM with timeout counter; produces stall,
// absorb (stale response swallowed) and timeout (load abandoned this cycle).
module mw_load_tracker #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic rvalid,
  input  logic req,
  output logic stall,
  output logic absorb,
  output logic timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    absorb    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (load && !rvalid) begin
          if (req) begin
            state_nxt = DRAIN;
          end else begin
            stall     = 1'b1;
            state_nxt = WAIT;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT: begin
        if (req) begin
          // A response arriving with the kill belongs to the killed load.
          absorb    = rvalid;
          state_nxt = rvalid ? IDLE : DRAIN;
        end else if (rvalid) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          // Stall drops on the timeout cycle so the dead load leaves M unwritten.
          timeout   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        stall = load && !req;
        if (rvalid) begin
          absorb    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/mw_result_stage.sv
// M-to-W result stage: decode, writeback source select and W register.
// Optional retire counter port enabled by defining MW_RETIRE_CNT_EN.
module mw_result_stage
  import mw_result_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 16
`ifdef MW_RETIRE_CNT_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid_i,
  input  logic [31:0]       instr_m_i,
  input  logic              reg_write_m_i,
  input  logic [ADDR_W-1:0] reg_addr_m_i,
  input  logic [DATA_W-1:0] reg_data_m_i,
  input  logic [DATA_W-1:0] cp0_data_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              req_i,
  output logic              stall_o,
  output logic              w_valid_o,
  output logic              w_reg_write_o,
  output logic [ADDR_W-1:0] w_reg_addr_o,
  output logic [DATA_W-1:0] w_reg_data_o,
`ifdef MW_RETIRE_CNT_EN
  output logic [CNT_W-1:0]  retire_cnt_o,
`endif
  output logic              bus_err_o
);

  logic [5:0]        op;
  logic [4:0]        rs, rt;
  logic              is_load, is_mfc0;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              stall, absorb, timeout, load_ok, commit;

  assign op      = instr_op(instr_m_i);
  assign rs      = instr_rs(instr_m_i);
  assign rt      = instr_rt(instr_m_i);
  assign is_load = is_load_op(op);
  assign is_mfc0 = (op == OP_COP0) && (rs == RS_MFC0);

  always_comb begin
    sel_we   = reg_write_m_i;
    sel_addr = reg_addr_m_i;
    sel_data = reg_data_m_i;
    if (is_load) begin
      sel_we   = 1'b1;
      sel_addr = ADDR_W'(rt);
      sel_data = mem_rdata_i;
    end else if (is_mfc0) begin
      sel_we   = 1'b1;
      sel_addr = ADDR_W'(rt);
      sel_data = cp0_data_i;
    end
  end

  mw_load_tracker #(
    .TIMEOUT(TIMEOUT)
  ) u_tracker (
    .clk    (clk),
    .reset  (reset),
    .load   (m_valid_i & is_load),
    .rvalid (mem_rvalid_i),
    .req    (req_i),
    .stall  (stall),
    .absorb (absorb),
    .timeout(timeout)
  );

  assign stall_o = stall;
  assign load_ok = mem_rvalid_i & ~absorb;
  assign commit  = m_valid_i & ~stall & ~req_i & ~timeout & (~is_load | load_ok);

  // M -> W register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid_o     <= 1'b0;
      w_reg_write_o <= 1'b0;
      w_reg_addr_o  <= '0;
      w_reg_data_o  <= '0;
      bus_err_o     <= 1'b0;
    end else begin
      w_valid_o     <= commit;
      w_reg_write_o <= commit & sel_we & (sel_addr != '0);
      bus_err_o     <= timeout;
      if (commit) begin
        w_reg_addr_o <= sel_addr;
        w_reg_data_o <= sel_data;
      end
    end
  end

`ifdef MW_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_o <= '0;
    end else if (commit) begin
      retire_cnt_o <= retire_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mw_result_stage.sv
// Bench for mw_result_stage: table of single-cycle vectors plus load/timeout/kill
// sequences, with a queue scoreboard on the W outputs. Honours MW_RETIRE_CNT_EN.
module tb_mw_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid_i;
  logic [31:0] instr_m_i;
  logic        reg_write_m_i;
  logic [4:0]  reg_addr_m_i;
  logic [31:0] reg_data_m_i;
  logic [31:0] cp0_data_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        req_i;
  logic        stall_o;
  logic        w_valid_o;
  logic        w_reg_write_o;
  logic [4:0]  w_reg_addr_o;
  logic [31:0] w_reg_data_o;
  logic        bus_err_o;
`ifdef MW_RETIRE_CNT_EN
  logic [31:0] retire_cnt_o;
`endif

  mw_result_stage #(
    .DATA_W (32),
    .ADDR_W (5),
    .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_valid_i    (m_valid_i),
    .instr_m_i    (instr_m_i),
    .reg_write_m_i(reg_write_m_i),
    .reg_addr_m_i (reg_addr_m_i),
    .reg_data_m_i (reg_data_m_i),
    .cp0_data_i   (cp0_data_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .req_i        (req_i),
    .stall_o      (stall_o),
    .w_valid_o    (w_valid_o),
    .w_reg_write_o(w_reg_write_o),
    .w_reg_addr_o (w_reg_addr_o),
    .w_reg_data_o (w_reg_data_o),
`ifdef MW_RETIRE_CNT_EN
    .retire_cnt_o (retire_cnt_o),
`endif
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [31:0] cp0;
    logic        rv;
    logic [31:0] md;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   n_commit = 0;

  localparam logic [31:0] ADDU3 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0010};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data;
    sb.push_back(e);
    n_commit++;
  endtask

  task automatic drive(input logic mv, input logic [31:0] ins, input logic rw,
                       input logic [4:0] ra, input logic [31:0] rd, input logic [31:0] cp0,
                       input logic rv, input logic [31:0] md, input logic rq);
    m_valid_i = mv; instr_m_i = ins; reg_write_m_i = rw; reg_addr_m_i = ra;
    reg_data_m_i = rd; cp0_data_i = cp0; mem_rvalid_i = rv; mem_rdata_i = md; req_i = rq;
  endtask

  task automatic idle(input logic rv, input logic [31:0] md);
    drive(1'b0, ADDU3, 1'b1, 5'd3, 32'hFFFF_0000, 32'h0, rv, md, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every W commit must match the oldest expected entry.
  always @(negedge clk) begin
    if (w_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w_unexpected: got w_valid_o=1 addr=%0d data=0x%0h expected no commit",
                 w_reg_addr_o, w_reg_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk("w_reg_write", {31'b0, w_reg_write_o}, {31'b0, mon_e.we});
        chk("w_reg_addr", {27'b0, w_reg_addr_o}, {27'b0, mon_e.addr});
        chk("w_reg_data", w_reg_data_o, mon_e.data);
      end
    end
  end

  initial begin
    vecs[0] = '{ADDU3, 1'b1, 5'd3, 32'h1234, 32'h0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h1234};
    vecs[1] = '{itype(6'h10, 5'd0, 5'd9), 1'b0, 5'd5, 32'hBAD, 32'h1000, 1'b0, 32'h0,
                1'b1, 5'd9, 32'h1000};
    vecs[2] = '{itype(6'h10, 5'd0, 5'd0), 1'b1, 5'd5, 32'hBAD, 32'h1000, 1'b0, 32'h0,
                1'b0, 5'd0, 32'h1000};
    vecs[3] = '{itype(6'h23, 5'd1, 5'd8), 1'b0, 5'd31, 32'hBAD, 32'h1000, 1'b1, 32'hCAFEF00D,
                1'b1, 5'd8, 32'hCAFEF00D};
    vecs[4] = '{itype(6'h20, 5'd1, 5'd4), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b1, 32'hFFFFFF80,
                1'b1, 5'd4, 32'hFFFFFF80};
    vecs[5] = '{itype(6'h25, 5'd1, 5'd6), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b1, 32'h0000BEEF,
                1'b1, 5'd6, 32'h0000BEEF};
    vecs[6] = '{itype(6'h21, 5'd1, 5'd7), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b1, 32'hFFFF8001,
                1'b1, 5'd7, 32'hFFFF8001};
    vecs[7] = '{itype(6'h24, 5'd1, 5'd2), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b1, 32'h7F,
                1'b1, 5'd2, 32'h7F};
    vecs[8] = '{ADDU3, 1'b1, 5'd0, 32'h5, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h5};
    vecs[9] = '{itype(6'h10, 5'd4, 5'd9), 1'b0, 5'd7, 32'h44, 32'h1000, 1'b0, 32'h0,
                1'b0, 5'd7, 32'h44};

    reset = 1'b1;
    idle(1'b0, 32'h0);
    @(negedge clk);
    chk("reset_w_valid", {31'b0, w_valid_o}, 32'h0);
    chk("reset_w_we", {31'b0, w_reg_write_o}, 32'h0);
    chk("reset_w_addr", {27'b0, w_reg_addr_o}, 32'h0);
    chk("reset_w_data", w_reg_data_o, 32'h0);
    chk("reset_bus_err", {31'b0, bus_err_o}, 32'h0);
    chk("reset_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].rw, vecs[i].ra, vecs[i].rd, vecs[i].cp0,
            vecs[i].rv, vecs[i].md, 1'b0);
      push(vecs[i].ewe, vecs[i].ea, vecs[i].ed);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), {31'b0, stall_o}, 32'h0);
      next_cycle();
    end
    idle(1'b0, 32'h0);
    next_cycle();

    // lw rt=8, data returns on the fourth cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, itype(6'h23, 5'd1, 5'd8), 1'b0, 5'd31, 32'hBAD, 32'h0,
            (k == 3), (k == 3) ? 32'hDEADBEEF : 32'h0, 1'b0);
      if (k == 3) push(1'b1, 5'd8, 32'hDEADBEEF);
      @(negedge clk);
      chk($sformatf("lw_wait_stall%0d", k), {31'b0, stall_o}, {31'b0, (k != 3)});
      next_cycle();
    end
    idle(1'b0, 32'h0);
    next_cycle();

    // Load that never returns: 16 stalled cycles, then the load is dropped
    for (int k = 0; k <= 16; k++) begin
      drive(1'b1, itype(6'h23, 5'd1, 5'd8), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("tmo_stall%0d", k), {31'b0, stall_o}, {31'b0, (k < 16)});
      chk("tmo_bus_err_low", {31'b0, bus_err_o}, 32'h0);
      next_cycle();
    end
    drive(1'b1, ADDU3, 1'b1, 5'd3, 32'h3333, 32'h0, 1'b0, 32'h0, 1'b0);
    push(1'b1, 5'd3, 32'h3333);
    @(negedge clk);
    chk("tmo_bus_err_pulse", {31'b0, bus_err_o}, 32'h1);
    chk("drain_nonload_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();
    drive(1'b1, itype(6'h23, 5'd1, 5'd10), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b1, 32'h55, 1'b0);
    @(negedge clk);
    chk("drain_load_stall", {31'b0, stall_o}, 32'h1);
    chk("tmo_bus_err_end", {31'b0, bus_err_o}, 32'h0);
    next_cycle();
    drive(1'b1, itype(6'h23, 5'd1, 5'd10), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b1, 32'h77, 1'b0);
    push(1'b1, 5'd10, 32'h77);
    @(negedge clk);
    chk("post_drain_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();

    // Kill a load in WAIT, then absorb its stale response
    drive(1'b1, itype(6'h23, 5'd1, 5'd11), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("req_miss_stall", {31'b0, stall_o}, 32'h1);
    next_cycle();
    drive(1'b1, itype(6'h23, 5'd1, 5'd11), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("req_wait_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();
    drive(1'b1, ADDU3, 1'b1, 5'd3, 32'hABCD, 32'h0, 1'b0, 32'h0, 1'b0);
    push(1'b1, 5'd3, 32'hABCD);
    @(negedge clk);
    chk("req_after_addu_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();
    idle(1'b1, 32'h66);
    next_cycle();
    drive(1'b1, itype(6'h23, 5'd1, 5'd15), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("req_idle_miss_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();
    idle(1'b1, 32'h67);
    next_cycle();
    drive(1'b1, itype(6'h23, 5'd1, 5'd12), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b1, 32'h99, 1'b0);
    push(1'b1, 5'd12, 32'h99);
    @(negedge clk);
    chk("absorbed_lw_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();
    drive(1'b1, ADDU3, 1'b1, 5'd3, 32'h4444, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("req_kill_addu_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();
    idle(1'b0, 32'h0);
    next_cycle();
    next_cycle();
    chk("sb_drained_pre_reset", sb.size(), 32'h0);
`ifdef MW_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt_o, n_commit);
`endif

    // Asynchronous reset while waiting on a load
    drive(1'b1, itype(6'h23, 5'd1, 5'd13), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("midwait_stall", {31'b0, stall_o}, 32'h1);
    #2;
    reset = 1'b1;
    m_valid_i = 1'b0;
    n_commit = 0;
    #1;
    chk("async_w_valid", {31'b0, w_valid_o}, 32'h0);
    chk("async_w_addr", {27'b0, w_reg_addr_o}, 32'h0);
    chk("async_w_data", w_reg_data_o, 32'h0);
    chk("async_stall", {31'b0, stall_o}, 32'h0);
`ifdef MW_RETIRE_CNT_EN
    chk("async_retire_cnt", retire_cnt_o, 32'h0);
`endif
    next_cycle();
    reset = 1'b0;
    drive(1'b1, itype(6'h23, 5'd1, 5'd14), 1'b0, 5'd31, 32'hBAD, 32'h0, 1'b1, 32'h1111, 1'b0);
    push(1'b1, 5'd14, 32'h1111);
    @(negedge clk);
    chk("post_reset_lw_stall", {31'b0, stall_o}, 32'h0);
    next_cycle();
    idle(1'b0, 32'h0);
    next_cycle();
    next_cycle();
    chk("sb_empty", sb.size(), 32'h0);
`ifdef MW_RETIRE_CNT_EN
    chk("retire_cnt_final", retire_cnt_o, n_commit);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mw_result_stage.md
Name: mw_result_stage

Overview:
- M-to-W result stage for the MIPS pipeline, as a parametrised successor to the combinational M-stage writeback select.
- Decodes the M-stage instruction and selects the writeback source: pass-through ALU/link data, load data, or CP0 read data.
- Supports variable-latency load returns through a valid handshake, with pipeline stall, timeout and a drain of stale responses.
- Registers the selected writeback request into W; an exception/interrupt request kills the write.

Parameters:
DATA_W, 32, width of register write data, load data and CP0 data
ADDR_W, 5, width of register file address
TIMEOUT, 16, max cycles waiting for mem_rvalid_i before bus error (>=1)
CNT_W, 32, width of retire counter (optional feature only)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
m_valid_i  in  1  valid instruction present in M
instr_m_i  in  32  M-stage instruction word
reg_write_m_i  in  1  M-stage write enable (non-load, non-mfc0 path)
reg_addr_m_i  in  ADDR_W  M-stage destination (non-load, non-mfc0 path)
reg_data_m_i  in  DATA_W  M-stage result data
cp0_data_i  in  DATA_W  CP0 read data for mfc0
mem_rvalid_i  in  1  load data valid from data memory/bus
mem_rdata_i  in  DATA_W  load data (already extended)
req_i  in  1  exception/interrupt request; kills current M write
stall_o  out  1  combinational; holds F/D/E/M when high
w_valid_o  out  1  W holds a committed instruction
w_reg_write_o  out  1  register write enable to GRF
w_reg_addr_o  out  ADDR_W  register write address
w_reg_data_o  out  DATA_W  register write data
bus_err_o  out  1  one-cycle pulse on load timeout

Behaviour:
- Decode: is_load when op in {0x23 lw, 0x21 lh, 0x20 lb, 0x25 lhu, 0x24 lbu}; is_mfc0 when op=0x10 and rs=0x00.
- Load and mfc0 write rt = instr_m_i[20:16] with write enable 1. Otherwise the reg_*_m_i inputs are used.
- Data selection priority: load -> mem_rdata_i; mfc0 -> cp0_data_i; else reg_data_m_i.
- Address 0: w_reg_write_o is forced 0 whenever the selected address is 0.
- Reset: state IDLE, timeout counter 0, all outputs 0.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - Non-load valid instruction with req_i=0: W registers loaded next edge, w_valid_o=1.
  - Load with mem_rvalid_i=1 in the same cycle: commits next edge, zero added latency.
  - Load with mem_rvalid_i=0: stall_o=1, -> WAIT, counter cleared.
- WAIT:
  - stall_o=1 while mem_rvalid_i=0; counter increments each cycle.
  - mem_rvalid_i=1: commit load next edge, stall_o=0 that cycle, -> IDLE.
  - Counter reaches TIMEOUT-1 with no data: bus_err_o pulses next cycle, no write (w_valid_o=0), -> DRAIN.
- DRAIN: one outstanding stale response is expected.
  - The first mem_rvalid_i is discarded, -> IDLE.
  - A new load arriving in DRAIN stalls (stall_o=1) until the stale response is absorbed, then proceeds as in IDLE.
  - Non-load instructions pass through DRAIN without stall.
- req_i=1:
  - Any cycle: the W register loads w_valid_o=0, w_reg_write_o=0.
  - In WAIT: -> DRAIN, stall_o=0.
  - In IDLE with a pending load miss: -> DRAIN, no stall.
  - req_i overrides a simultaneous mem_rvalid_i; that response counts as absorbed, -> IDLE.
- m_valid_i=0 with no stall: W loads w_valid_o=0, w_reg_write_o=0.
- While stall_o=1, W loads a bubble (w_valid_o=0) each cycle.
- Reset mid-WAIT: immediate return to IDLE, outstanding response not drained.

Optional Feature:
- Macro MW_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt_o [CNT_W-1:0], reset 0.
  - Increments on every edge that loads w_valid_o=1; wraps modulo 2^CNT_W.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package/define file holds opcode constants (lw/lh/lb/lhu/lbu/cop0 op, mfc0 rs) and the instruction field slices (op, rs, rt).
- State encoding as localparams in the block.
- One natural sub-module, mw_load_tracker: FSM plus timeout counter, outputs stall, absorb and timeout.
- The top keeps decode, select and W registers.

Test Plan:
- addu $3 result 0x1234, reg_write_m_i=1, addr 3 -> next cycle w_reg_write_o=1, addr 3, data 0x1234, stall_o=0 throughout.
- lw rt=8 with mem_rvalid_i after 3 cycles, rdata 0xDEADBEEF -> stall_o high 3 cycles, then w addr 8, data 0xDEADBEEF, exactly one w_valid_o pulse.
- mfc0 rt=9, cp0_data_i=0x0000_1000 -> w addr 9, data 0x1000, write 1; a second case with rt=0 -> w_reg_write_o=0.
- Load, rvalid never returns, TIMEOUT=16 -> bus_err_o single pulse after 16 wait cycles, no write; late rvalid with 0x55 discarded; next lw returns 0x77 -> written correctly.
- lw in WAIT, req_i=1 -> stall_o drops the same cycle, no write; next instruction addu commits normally; the stale rvalid is absorbed.
- With MW_RETIRE_CNT_EN: 5 committed instructions, 1 killed by req_i, 1 timeout -> retire_cnt_o=5; async reset mid-stream -> all outputs 0 immediately.
